// File: rtl/mult_ctrl_add.sv
// mult_ctrl_add: control and add stage of an N-bit shift-add multiplier.
// Latches the operands, adds the multiplicand into the accumulator when the
// current multiplier LSB is set, hands {acc,q} to the downstream shift stage,
// strobes its active-low start, reads the shifted pair back, and after N
// iterations presents the 2N-bit product.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             operation request, sampled only when idle
//   x, y              multiplicand / multiplier, latched on accept
//   sh_acc_o, sh_q_o  accumulator / multiplier presented to the shift stage
//   sh_start_n        low for one cycle to make the shift stage shift
//   sh_acc_i, sh_q_i  shifted accumulator / multiplier from the shift stage
//   busy              high from accept through the done cycle
//   done              one-cycle pulse when product is valid
//   product           result, held until overwritten by the next result
module mult_ctrl_add #(
   parameter int unsigned N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   x,
   input  logic [N-1:0]   y,
   output logic [N:0]     sh_acc_o,
   output logic [N-1:0]   sh_q_o,
   output logic           sh_start_n,
   input  logic [N:0]     sh_acc_i,
   input  logic [N-1:0]   sh_q_i,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int unsigned AW = N + 1;
   localparam int unsigned PW = 2 * N;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADD   = 3'd1,
      SHIFT = 3'd2,
      CAPT  = 3'd3,
      DONE  = 3'd4
   } state_e;

   state_e          state_q;
   logic [N-1:0]    m_q;
   logic [AW-1:0]   acc_q;
   logic [N-1:0]    q_q;
   logic [CW-1:0]   cnt_q;
   logic            sh_start_n_q;
   logic            busy_q;
   logic            done_q;
   logic [PW-1:0]   product_q;

   // FSM and datapath; the strobe/status outputs are registered from the
   // state being entered so they line up exactly with that state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         m_q          <= '0;
         acc_q        <= '0;
         q_q          <= '0;
         cnt_q        <= '0;
         sh_start_n_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         product_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  m_q     <= x;
                  acc_q   <= '0;
                  q_q     <= y;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ADD;
               end
            end
            ADD: begin
               // acc < 2^N here, so the N+1-bit sum cannot overflow
               if (q_q[0]) begin
                  acc_q <= acc_q + {1'b0, m_q};
               end
               sh_start_n_q <= 1'b0;
               state_q      <= SHIFT;
            end
            SHIFT: begin
               sh_start_n_q <= 1'b1;
               state_q      <= CAPT;
            end
            CAPT: begin
               acc_q <= sh_acc_i;
               q_q   <= sh_q_i;
               if (cnt_q == CW'(N - 1)) begin
                  product_q <= {sh_acc_i[N-1:0], sh_q_i};
                  done_q    <= 1'b1;
                  state_q   <= DONE;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
                  state_q <= ADD;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               sh_start_n_q <= 1'b1;
               busy_q       <= 1'b0;
               done_q       <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign sh_acc_o   = acc_q;
   assign sh_q_o     = q_q;
   assign sh_start_n = sh_start_n_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign product    = product_q;

endmodule

// File: tb/tb_mult_ctrl_add.sv
// tb_mult_ctrl_add: directed bench for mult_ctrl_add with a behavioural
// shift stage attached ({acc,q} >> 1 on each low sh_start_n edge).
module tb_mult_ctrl_add;

   localparam int unsigned N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [N-1:0]   x;
   logic [N-1:0]   y;
   logic [N:0]     sh_acc_o;
   logic [N-1:0]   sh_q_o;
   logic           sh_start_n;
   logic [N:0]     sh_acc_i;
   logic [N-1:0]   sh_q_i;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mult_ctrl_add #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .x          (x),
      .y          (y),
      .sh_acc_o   (sh_acc_o),
      .sh_q_o     (sh_q_o),
      .sh_start_n (sh_start_n),
      .sh_acc_i   (sh_acc_i),
      .sh_q_i     (sh_q_i),
      .busy       (busy),
      .done       (done),
      .product    (product)
   );

   // Shift stage model: unreset, shifts the presented pair right by one.
   always @(posedge clk) begin
      if (!sh_start_n) begin
         {sh_acc_i, sh_q_i} <= {sh_acc_o, sh_q_o} >> 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One operation: accept, then observe 14 cycles (k=0 right after the
   // accepting edge). Pulses expected at k=1,4,7,10; done at k=12; idle at k=13.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold,
                         input string tag, output logic [3:0][N:0] tr);
      logic [2*N-1:0] exp;
      int pulses, dones, first_p, last_p, done_k, busy_bad;
      exp      = (2*N)'(a) * (2*N)'(b);
      pulses   = 0;
      dones    = 0;
      first_p  = -1;
      last_p   = -1;
      done_k   = -1;
      busy_bad = 0;
      tr       = '0;
      x        = a;
      y        = b;
      start    = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      x = ~a;
      y = ~b;
      for (int k = 0; k <= 13; k++) begin
         if (!sh_start_n) begin
            if (first_p < 0) first_p = k;
            last_p = k;
            if (pulses < 4) tr[pulses] = sh_acc_o;
            pulses++;
         end
         if (done) begin
            dones++;
            done_k = k;
         end
         if (k <= 12 && busy !== 1'b1) busy_bad++;
         if (k < 13) tick();
      end
      chk({tag, " pulses"},     32'(pulses),   32'd4);
      chk({tag, " first_pulse"}, 32'(first_p), 32'd1);
      chk({tag, " last_pulse"}, 32'(last_p),   32'd10);
      chk({tag, " done_count"}, 32'(dones),    32'd1);
      chk({tag, " done_k"},     32'(done_k),   32'd12);
      chk({tag, " busy_gap"},   32'(busy_bad), 32'd0);
      chk({tag, " busy_end"},   32'(busy),     32'd0);
      chk({tag, " product"},    32'(product),  32'(exp));
   endtask

   initial begin : stim
      logic [3:0][N:0] tr;
      int bad;
      rst   = 1'b1;
      start = 1'b0;
      x     = '0;
      y     = '0;
      tick();
      tick();

      // Reset state
      chk("rst sh_acc_o",   32'(sh_acc_o),   32'd0);
      chk("rst sh_q_o",     32'(sh_q_o),     32'd0);
      chk("rst sh_start_n", 32'(sh_start_n), 32'd1);
      chk("rst busy",       32'(busy),       32'd0);
      chk("rst done",       32'(done),       32'd0);
      chk("rst product",    32'(product),    32'd0);

      // Reset and start together: start dropped
      start = 1'b1;
      x     = 4'd5;
      y     = 4'd5;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_start busy", 32'(busy), 32'd0);
      tick();
      chk("rst_start idle", 32'(busy), 32'd0);

      // 13 x 11: acc after each ADD = 13, 19, 9, 17
      run_op(4'd13, 4'd11, 1'b0, "t1", tr);
      chk("t1 acc0", 32'(tr[0]), 32'd13);
      chk("t1 acc1", 32'(tr[1]), 32'd19);
      chk("t1 acc2", 32'(tr[2]), 32'd9);
      chk("t1 acc3", 32'(tr[3]), 32'd17);
      chk("t1 product_hex", 32'(product), 32'h8F);

      // 15 x 15: acc after each ADD = 15, 22, 26, 28 (bit 4 set from 2nd ADD)
      run_op(4'd15, 4'd15, 1'b0, "t2", tr);
      chk("t2 acc0", 32'(tr[0]), 32'd15);
      chk("t2 acc1", 32'(tr[1]), 32'b10110);
      chk("t2 acc2", 32'(tr[2]), 32'd26);
      chk("t2 acc3", 32'(tr[3]), 32'b11100);
      chk("t2 product_hex", 32'(product), 32'hE1);

      // Zero operands
      run_op(4'd0, 4'd9, 1'b0, "t3a", tr);
      run_op(4'd9, 4'd0, 1'b0, "t3b", tr);

      // start held high: restarts only after IDLE, product holds until then
      run_op(4'd3, 4'd5, 1'b1, "t4a", tr);
      chk("t4 hold_product", 32'(product), 32'd15);
      run_op(4'd3, 4'd5, 1'b1, "t4b", tr);
      start = 1'b0;
      tick();
      tick();
      chk("t4 idle_after", 32'(busy), 32'd0);

      // Reset during the SHIFT of iteration 2 (k=4)
      x     = 4'd13;
      y     = 4'd11;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("t5 in_shift", 32'(sh_start_n), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5 sh_acc_o",   32'(sh_acc_o),   32'd0);
      chk("t5 sh_q_o",     32'(sh_q_o),     32'd0);
      chk("t5 sh_start_n", 32'(sh_start_n), 32'd1);
      chk("t5 busy",       32'(busy),       32'd0);
      chk("t5 done",       32'(done),       32'd0);
      chk("t5 product",    32'(product),    32'd0);
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (sh_start_n !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("t5 no_extra_shift", 32'(bad), 32'd0);
      run_op(4'd6, 4'd7, 1'b0, "t5", tr);
      chk("t5 product42", 32'(product), 32'd42);

      // Exhaustive, back-to-back starts
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_op(4'(a), 4'(b), 1'b0, "t6", tr);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
